// File: rtl/mem_arbiter.sv
// Two-requester arbiter for one single-port memory: instruction fetch vs load/store.
// Round-robin on ties, registered memory port, per-transaction timeout abort.
module mem_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_gnt,
   output logic                  if_done,
   output logic [DATA_WIDTH-1:0] if_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   input  logic [3:0]            d_be,
   output logic                  d_gnt,
   output logic                  d_done,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  err,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_be,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, DONE} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t                r_state;
   logic                  r_last_d;
   logic [7:0]            r_cnt;
   logic                  r_if_done;
   logic                  r_d_done;
   logic                  r_err;
   logic                  r_busy;
   logic [DATA_WIDTH-1:0] r_if_rdata;
   logic [DATA_WIDTH-1:0] r_d_rdata;
   logic                  r_mem_req;
   logic                  r_mem_we;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0] r_mem_wdata;
   logic [3:0]            r_mem_be;

   logic w_gnt_if;
   logic w_gnt_d;
   logic w_timeout;

   // Grants depend only on the requests and registered state, never on mem_ack.
   // On a tie the requester that did not own the last transaction wins.
   assign w_gnt_if  = (r_state == IDLE) && if_req && (!d_req || r_last_d);
   assign w_gnt_d   = (r_state == IDLE) && d_req  && (!if_req || !r_last_d);
   assign w_timeout = (r_cnt == CNT_LAST);

   // NOTE: all state below uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_last_d    <= 1'b1;
         r_cnt       <= '0;
         r_if_done   <= 1'b0;
         r_d_done    <= 1'b0;
         r_err       <= 1'b0;
         r_busy      <= 1'b0;
         r_if_rdata  <= '0;
         r_d_rdata   <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_be    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_gnt_if) begin
                  r_state     <= BUSY_IF;
                  r_last_d    <= 1'b0;
                  r_cnt       <= '0;
                  r_busy      <= 1'b1;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= 1'b0;
                  r_mem_addr  <= if_addr;
                  r_mem_wdata <= '0;
                  r_mem_be    <= 4'hF;
               end else if (w_gnt_d) begin
                  r_state     <= BUSY_D;
                  r_last_d    <= 1'b1;
                  r_cnt       <= '0;
                  r_busy      <= 1'b1;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= d_we;
                  r_mem_addr  <= d_addr;
                  r_mem_wdata <= d_wdata;
                  r_mem_be    <= d_be;
               end
            end
            BUSY_IF, BUSY_D: begin
               if (mem_ack) begin
                  if (r_state == BUSY_IF)
                     r_if_rdata <= mem_rdata;
                  else if (!r_mem_we)
                     r_d_rdata <= mem_rdata;
                  r_err     <= 1'b0;
                  r_mem_req <= 1'b0;
                  r_if_done <= (r_state == BUSY_IF);
                  r_d_done  <= (r_state == BUSY_D);
                  r_state   <= DONE;
               end else if (w_timeout) begin
                  // Abort: report completion with err, read data left untouched.
                  r_err     <= 1'b1;
                  r_mem_req <= 1'b0;
                  r_if_done <= (r_state == BUSY_IF);
                  r_d_done  <= (r_state == BUSY_D);
                  r_state   <= DONE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            DONE: begin
               r_if_done <= 1'b0;
               r_d_done  <= 1'b0;
               r_err     <= 1'b0;
               r_busy    <= 1'b0;
               r_state   <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign if_gnt    = w_gnt_if;
   assign d_gnt     = w_gnt_d;
   assign if_done   = r_if_done;
   assign d_done    = r_d_done;
   assign if_rdata  = r_if_rdata;
   assign d_rdata   = r_d_rdata;
   assign err       = r_err;
   assign busy      = r_busy;
   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign mem_be    = r_mem_be;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, fetch, round-robin ties, store,
// timeout abort, stray ack and dropped request.
module tb_mem_arbiter;

   localparam int DW = 32;
   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt;
   logic          if_done;
   logic [DW-1:0] if_rdata;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [3:0]    d_be;
   logic          d_gnt;
   logic          d_done;
   logic [DW-1:0] d_rdata;
   logic          err;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [3:0]    mem_be;
   logic          mem_ack;
   logic [DW-1:0] mem_rdata;
   logic          busy;

   int n_total = 0;
   int n_bad   = 0;

   mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata), .err(err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   logic       exp_if [3] = '{1'b1, 1'b0, 1'b1};
   logic [31:0] tie_data [3] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};

   initial begin
      rst = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
      d_addr = '0; d_wdata = '0; d_be = '0; mem_ack = 1'b0; mem_rdata = '0;

      // Reset state
      #3;
      check("rst_busy", busy, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_if_rdata", if_rdata, 0);
      check("rst_err", err, 0);
      tick; tick;
      rst = 1'b1;
      tick;

      // Single fetch with ack on first busy cycle
      if_req = 1'b1; if_addr = 32'h0000_0010;
      #1;
      check("fetch_gnt", if_gnt, 1);
      check("fetch_dgnt", d_gnt, 0);
      tick;
      if_req = 1'b0;
      check("fetch_mem_req", mem_req, 1);
      check("fetch_mem_addr", mem_addr, 32'h10);
      check("fetch_mem_we", mem_we, 0);
      check("fetch_mem_be", mem_be, 4'hF);
      check("fetch_gnt_busy", if_gnt, 0);
      mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
      tick;
      mem_ack = 1'b0;
      check("fetch_done", if_done, 1);
      check("fetch_rdata", if_rdata, 32'h0050_0093);
      check("fetch_err", err, 0);
      check("fetch_mem_req_drop", mem_req, 0);
      tick;
      check("fetch_done_pulse", if_done, 0);
      check("fetch_idle", busy, 0);

      // Reset in the middle of a load
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_be = 4'hF;
      #1;
      check("rstmid_gnt", d_gnt, 1);
      tick;
      d_req = 1'b0;
      check("rstmid_mem_req", mem_req, 1);
      tick;
      #2 rst = 1'b0;
      #1;
      check("rstmid_async_mem_req", mem_req, 0);
      check("rstmid_async_busy", busy, 0);
      tick; tick;
      rst = 1'b1;
      check("rstmid_d_done", d_done, 0);
      check("rstmid_if_rdata", if_rdata, 0);
      check("rstmid_mem_addr", mem_addr, 0);
      tick;
      check("rstmid_d_done2", d_done, 0);
      check("rstmid_busy2", busy, 0);

      // Tie: both held, expect IF, D, IF with one idle cycle between
      if_addr = 32'h20; d_addr = 32'h80; d_we = 1'b0; d_be = 4'hF;
      for (int t = 0; t < 3; t++) begin
         if_req = 1'b1; d_req = 1'b1;
         #1;
         check("tie_idle_gap", busy, 0);
         check("tie_if_gnt", if_gnt, exp_if[t]);
         check("tie_d_gnt", d_gnt, !exp_if[t]);
         tick;
         check("tie_busy", busy, 1);
         check("tie_mem_addr", mem_addr, exp_if[t] ? 32'h20 : 32'h80);
         check("tie_no_gnt", if_gnt | d_gnt, 0);
         mem_ack = 1'b1; mem_rdata = tie_data[t];
         tick;
         mem_ack = 1'b0;
         check("tie_if_done", if_done, exp_if[t]);
         check("tie_d_done", d_done, !exp_if[t]);
         tick;
      end
      if_req = 1'b0; d_req = 1'b0;
      check("tie_if_rdata", if_rdata, 32'h3333_3333);
      check("tie_d_rdata", d_rdata, 32'h2222_2222);
      tick;

      // Store with four wait cycles
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
      #1;
      check("st_gnt", d_gnt, 1);
      tick;
      d_req = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("st_mem_req", mem_req, 1);
         check("st_mem_we", mem_we, 1);
         check("st_mem_addr", mem_addr, 32'h100);
         check("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
         check("st_mem_be", mem_be, 4'b0011);
         check("st_early_done", d_done, 0);
         if (i == 4) begin
            mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
         end
         tick;
      end
      mem_ack = 1'b0;
      check("st_done", d_done, 1);
      check("st_err", err, 0);
      check("st_rdata_kept", d_rdata, 32'h2222_2222);
      check("st_mem_req_drop", mem_req, 0);
      tick;
      check("st_done_pulse", d_done, 0);
      check("st_idle", busy, 0);

      // Timeout: no ack, TIMEOUT=8
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_be = 4'hF;
      #1;
      check("to_gnt", d_gnt, 1);
      tick;
      d_req = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("to_mem_req", mem_req, 1);
         check("to_early_done", d_done, 0);
         tick;
      end
      check("to_mem_req_drop", mem_req, 0);
      check("to_done", d_done, 1);
      check("to_err", err, 1);
      check("to_rdata_kept", d_rdata, 32'h2222_2222);
      tick;
      check("to_idle", busy, 0);
      check("to_err_clear", err, 0);
      check("to_done_pulse", d_done, 0);

      // Request raised and dropped while busy, then stray acks in IDLE
      if_req = 1'b1; if_addr = 32'h300;
      #1;
      check("drop_if_gnt", if_gnt, 1);
      tick;
      if_req = 1'b0;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
      #1;
      check("drop_d_gnt_busy", d_gnt, 0);
      mem_ack = 1'b1; mem_rdata = 32'h4444_4444;
      tick;
      d_req = 1'b0;
      mem_rdata = 32'h5555_5555;
      tick;
      check("drop_idle", busy, 0);
      for (int i = 0; i < 3; i++) begin
         tick;
         check("stray_busy", busy, 0);
         check("stray_mem_req", mem_req, 0);
         check("stray_done", if_done | d_done, 0);
         check("stray_gnt", if_gnt | d_gnt, 0);
      end
      mem_ack = 1'b0;
      check("stray_if_rdata", if_rdata, 32'h4444_4444);
      check("stray_d_rdata", d_rdata, 32'h2222_2222);
      check("stray_mem_addr", mem_addr, 32'h300);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
